// File: rtl/pushbutton_debouncer.sv
// Push-button debouncer with single, multiple and continuous clock enables.
// Define DEBOUNCER_SYNC_EN to add a 2-flop input synchronizer on PB.
module pushbutton_debouncer #(
    parameter int N_dc = 21
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN,
    output logic CCEN
);

    typedef enum logic [2:0] {
        INI,
        W84,
        SCEN_ST,
        WS,
        MCEN_ST,
        CCEN_ST,
        CCR
    } state_t;

    localparam logic [N_dc-1:0] C_MAX = '1;

    state_t          r_state;
    logic [N_dc-1:0] r_cnt;
    logic [1:0]      r_rc;
    logic [3:0]      r_out;
    logic            w_pb;

`ifdef DEBOUNCER_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], PB};
        end
    end

    assign w_pb = r_sync[1];
`else
    assign w_pb = PB;
`endif

    // Output bits are {DPB, SCEN, MCEN, CCEN} for the state being entered.
    function automatic logic [3:0] f_out(input state_t s);
        logic [3:0] o;
        o = 4'b0000;
        unique case (s)
            SCEN_ST: o = 4'b1111;
            WS:      o = 4'b1000;
            MCEN_ST: o = 4'b1010;
            CCEN_ST: o = 4'b1001;
            CCR:     o = 4'b1000;
            default: o = 4'b0000;
        endcase
        return o;
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= INI;
            r_cnt   <= '0;
            r_rc    <= '0;
            r_out   <= '0;
        end else begin
            unique case (r_state)
                INI: begin
                    r_cnt <= '0;
                    r_rc  <= '0;
                    if (w_pb) begin
                        r_state <= W84;
                        r_out   <= f_out(W84);
                    end
                end
                W84: begin
                    if (!w_pb) begin
                        r_state <= INI;
                        r_out   <= f_out(INI);
                    end else if (r_cnt == C_MAX) begin
                        r_state <= SCEN_ST;
                        r_out   <= f_out(SCEN_ST);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SCEN_ST: begin
                    r_cnt   <= '0;
                    r_state <= WS;
                    r_out   <= f_out(WS);
                end
                WS: begin
                    if (!w_pb) begin
                        r_cnt   <= '0;
                        r_state <= CCR;
                        r_out   <= f_out(CCR);
                    end else if (r_cnt == C_MAX) begin
                        r_cnt   <= '0;
                        r_state <= MCEN_ST;
                        r_out   <= f_out(MCEN_ST);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                MCEN_ST: begin
                    if (r_rc == 2'd3) begin
                        r_state <= CCEN_ST;
                        r_out   <= f_out(CCEN_ST);
                    end else begin
                        r_rc    <= r_rc + 1'b1;
                        r_state <= WS;
                        r_out   <= f_out(WS);
                    end
                end
                CCEN_ST: begin
                    if (!w_pb) begin
                        r_cnt   <= '0;
                        r_state <= CCR;
                        r_out   <= f_out(CCR);
                    end
                end
                CCR: begin
                    // Any bounce back to 1 restarts the release timer.
                    if (w_pb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_MAX) begin
                        r_state <= INI;
                        r_out   <= f_out(INI);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= INI;
                    r_out   <= f_out(INI);
                end
            endcase
        end
    end

    assign {DPB, SCEN, MCEN, CCEN} = r_out;

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Randomized and directed bench for pushbutton_debouncer against an
// age/run-length reference model (N_dc = 4).
module tb_pushbutton_debouncer;

    localparam int N  = 4;
    localparam int T  = 1 << N;
    localparam int P  = T + 1;
    localparam int NP = 4;
`ifdef DEBOUNCER_SYNC_EN
    localparam int LAT_ADD = 2;
`else
    localparam int LAT_ADD = 0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_HELD = 1;
    localparam int M_REL  = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic pb;
    logic dpb, scen, mcen, ccen;
    logic [3:0] w_o;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    int   m_mode, m_r, m_a, m_z;
    logic m_s1, m_s2;
    logic [3:0] m_out;

    pushbutton_debouncer #(.N_dc(N)) dut (
        .CLK  (clk),
        .RESET(rst_n),
        .PB   (pb),
        .DPB  (dpb),
        .SCEN (scen),
        .MCEN (mcen),
        .CCEN (ccen)
    );

    assign w_o = {dpb, scen, mcen, ccen};

    always #5 clk = ~clk;

    function automatic bit is_pulse(input int x);
        return (x >= 0) && (x <= NP * P) && (x % P == 0);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_r = 0; m_a = 0; m_z = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
        m_out = 4'b0000;
    endtask

    // Idle: accept on the (T+1)th consecutive 1. Held: age a counts edges
    // since acceptance; release is seen only when the previous cycle was not
    // a pulse cycle. Release: T consecutive 0s return to idle.
    task automatic model_edge(input logic v);
        logic p;
        if (LAT_ADD != 0) begin
            p = m_s2; m_s2 = m_s1; m_s1 = v;
        end else begin
            p = v;
        end
        case (m_mode)
            M_IDLE: begin
                if (p) begin
                    m_r++;
                    if (m_r == P) begin
                        m_mode = M_HELD; m_a = 0; m_r = 0;
                    end
                end else begin
                    m_r = 0;
                end
            end
            M_HELD: begin
                m_a++;
                if (!p && !is_pulse(m_a - 1)) begin
                    m_mode = M_REL; m_z = 0;
                end
            end
            default: begin
                if (p) m_z = 0;
                else begin
                    m_z++;
                    if (m_z == T) m_mode = M_IDLE;
                end
            end
        endcase
        case (m_mode)
            M_HELD: m_out = {1'b1, m_a == 0, is_pulse(m_a),
                             (m_a == 0) || (m_a > NP * P)};
            M_REL:  m_out = 4'b1000;
            default: m_out = 4'b0000;
        endcase
    endtask

    task automatic step(input logic v);
        pb = v;
        @(posedge clk);
        model_edge(v);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        int k;
        bit got;
        @(posedge clk); #1;
        rst_n = 1'b0; pb = 1'b1;
        model_reset();
        repeat (4) begin
            @(posedge clk); #1;
            n_chk++;
            if (w_o !== 4'b0000)
                $display("FAIL reset_hold got=%b exp=0000", w_o);
            else n_pass++;
        end
        rst_n = 1'b1;
        step(1'b1);
        n_chk++;
        if (w_o !== 4'b0000)
            $display("FAIL reset_after got=%b exp=0000", w_o);
        else n_pass++;
        k = 1; got = 0;
        while (!got && k < 60) begin
            step(1'b1); k++;
            if (scen === 1'b1) got = 1;
        end
        n_chk++;
        if (k != P + LAT_ADD)
            $display("FAIL reset_latency got=%0d exp=%0d", k, P + LAT_ADD);
        else n_pass++;
        repeat (40) step(1'b0);
    endtask

    task automatic test_glitch();
        int hi;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            step(i < 10);
            if (scen || mcen || dpb) hi++;
            n_chk++;
            if (w_o !== m_out)
                $display("FAIL glitch cyc=%0d got=%b exp=%b", cyc, w_o, m_out);
            else n_pass++;
        end
        n_chk++;
        if (hi != 0) $display("FAIL glitch_out got=%0d exp=0", hi);
        else n_pass++;
    endtask

    task automatic test_single_press();
        int ns, nd;
        ns = 0; nd = 0;
        for (int i = 0; i < 60; i++) begin
            step(i < 20);
            if (scen) begin
                ns++;
                n_chk++;
                if (!(mcen && ccen && dpb))
                    $display("FAIL single_coinc got=%b exp=1111", w_o);
                else n_pass++;
            end
            if (dpb) nd++;
            n_chk++;
            if (w_o !== m_out)
                $display("FAIL single cyc=%0d got=%b exp=%b", cyc, w_o, m_out);
            else n_pass++;
        end
        n_chk++;
        if (ns != 1) $display("FAIL single_scen got=%0d exp=1", ns);
        else n_pass++;
        n_chk++;
        if (nd != 20) $display("FAIL single_dpb got=%0d exp=20", nd);
        else n_pass++;
    endtask

    task automatic test_long_hold();
        int ns, nm, nc, last, bad;
        ns = 0; nm = 0; nc = 0; last = -1; bad = 0;
        for (int i = 0; i < 240; i++) begin
            step(i < 200);
            if (scen) ns++;
            if (mcen) begin
                nm++;
                if (last >= 0 && i - last != P) bad++;
                last = i;
            end
            if (ccen) nc++;
            n_chk++;
            if (w_o !== m_out)
                $display("FAIL long cyc=%0d got=%b exp=%b", cyc, w_o, m_out);
            else n_pass++;
        end
        n_chk++;
        if (ns != 1) $display("FAIL long_scen got=%0d exp=1", ns);
        else n_pass++;
        n_chk++;
        if (nm != 5) $display("FAIL long_mcen got=%0d exp=5", nm);
        else n_pass++;
        n_chk++;
        if (bad != 0) $display("FAIL long_spacing got=%0d exp=0", bad);
        else n_pass++;
        n_chk++;
        if (nc != 116) $display("FAIL long_ccen got=%0d exp=116", nc);
        else n_pass++;
    endtask

    task automatic test_release_bounce();
        int ns, fall;
        logic v;
        ns = 0; fall = -1;
        for (int i = 1; i <= 80; i++) begin
            v = (i <= 20) || (i == 32);
            step(v);
            if (scen) ns++;
            if (i > 32 && fall < 0 && !dpb) fall = i;
            n_chk++;
            if (w_o !== m_out)
                $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, w_o, m_out);
            else n_pass++;
        end
        n_chk++;
        if (ns != 1) $display("FAIL bounce_scen got=%0d exp=1", ns);
        else n_pass++;
        n_chk++;
        if (fall - 32 - LAT_ADD != T)
            $display("FAIL bounce_fall got=%0d exp=%0d", fall - 32 - LAT_ADD, T);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int k;
        bit got;
        repeat (25) step(1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (w_o !== 4'b0000)
            $display("FAIL midreset_async got=%b exp=0000", w_o);
        else n_pass++;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        k = 0; got = 0;
        while (!got && k < 60) begin
            step(1'b1); k++;
            if (scen === 1'b1) got = 1;
        end
        n_chk++;
        if (k != P + LAT_ADD)
            $display("FAIL midreset_latency got=%0d exp=%0d", k, P + LAT_ADD);
        else n_pass++;
        repeat (40) step(1'b0);
    endtask

    task automatic test_random();
        int len, err;
        logic v;
        v = 1'b0; err = 0;
        for (int r = 0; r < 120; r++) begin
            v = ~v;
            if ($urandom_range(0, 5) == 0) len = $urandom_range(60, 120);
            else len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                step(v);
                n_chk++;
                if (w_o !== m_out) begin
                    err++;
                    if (err < 10)
                        $display("FAIL random cyc=%0d got=%b exp=%b",
                                 cyc, w_o, m_out);
                end else n_pass++;
            end
        end
        repeat (40) step(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        pb = 1'b0;
        model_reset();
        test_reset();
        test_glitch();
        test_single_press();
        test_long_hold();
        test_release_bounce();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pushbutton_debouncer.md
Name: pushbutton_debouncer

Overview:
- Debounces one raw push-button input and produces four conditioned outputs:
  - DPB: debounced level.
  - SCEN: single-clock enable, one pulse per press.
  - MCEN: multiple-clock enable, repeats while held.
  - CCEN: continuous-clock enable, high every cycle after a long hold.
- One instance per board button (U/D/L/R/C), sitting between the pad and game logic such as movement and start/ack.

Parameters:
- N_dc, default 21: width of the debounce/timing counter. One timing interval T = 2^N_dc clocks, about 21 ms at 100 MHz.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PB  in  1  raw push-button level, active-high; may bounce.
- DPB  out  1  debounced button level.
- SCEN  out  1  one-cycle pulse per accepted press.
- MCEN  out  1  one-cycle pulses: at press, then repeating while held.
- CCEN  out  1  high on the press cycle, then high every cycle once continuous mode is reached.

Behaviour:
- Storage:
  - State register of 7 states.
  - Counter cnt, N_dc bits.
  - MCEN repeat counter rc, 2 bits.
- Reset (RESET=0, asynchronous): state=INI, cnt=0, rc=0. All outputs 0 while reset is asserted and in the cycle after release.
- Outputs are Moore, decoded purely from state. No PB-to-output combinational path.
- INI:
  - cnt<=0, rc<=0.
  - If PB=1, go to W84.
  - Outputs all 0.
- W84 (press debounce):
  - If PB=0: go to INI.
  - Else if cnt==2^N_dc-1: go to SCEN_ST.
  - Else cnt<=cnt+1.
  - Outputs all 0.
- SCEN_ST (exactly 1 cycle):
  - SCEN=MCEN=CCEN=DPB=1.
  - cnt<=0; go to WS.
- WS (hold wait):
  - DPB=1, others 0.
  - If PB=0: go to CCR with cnt<=0.
  - Else if cnt==2^N_dc-1: cnt<=0 and go to MCEN_ST.
  - Else cnt<=cnt+1.
- MCEN_ST (exactly 1 cycle):
  - DPB=MCEN=1.
  - If rc==3: go to CCEN_ST.
  - Else rc<=rc+1 and go to WS.
- CCEN_ST:
  - DPB=CCEN=1 every cycle; MCEN=0; SCEN=0.
  - If PB=0: cnt<=0 and go to CCR.
- CCR (release debounce):
  - DPB=1, all enables 0.
  - If PB=1: cnt<=0 and stay.
  - Else if cnt==2^N_dc-1: go to INI.
  - Else cnt<=cnt+1.
- Timing:
  - SCEN rises 2^N_dc+1 clocks after the first rising edge that samples PB=1, provided PB stays 1.
  - In WS/MCEN_ST looping, MCEN period is 2^N_dc+1 clocks.
  - The sequence is: SCEN_ST pulse, then 4 further MCEN pulses, then CCEN_ST.
- Boundary conditions:
  - A glitch shorter than 2^N_dc clocks never reaches SCEN_ST.
  - Counter never wraps; the compare happens before the increment.
  - PB bounce during CCR restarts the release timer; no new SCEN is issued until the block passes INI again.
  - Reset asserted mid-press returns to INI immediately. A press still held after reset release must re-qualify through W84.

Optional Feature:
- Macro: DEBOUNCER_SYNC_EN.
- Defined:
  - PB passes through a 2-flop synchronizer, reset to 0, before the FSM.
  - All PB-relative latencies grow by exactly 2 clocks.
- Undefined: PB is sampled directly by the FSM.

Test Plan:
- Reset: N_dc=4, hold RESET=0 with PB=1 → DPB=SCEN=MCEN=CCEN=0. After release, SCEN first pulses 17 clocks after the first PB=1 sample.
- Glitch rejection: N_dc=4, PB=1 for 10 clocks then 0 → SCEN, MCEN and DPB stay 0 throughout.
- Single press: N_dc=4, PB=1 for 20 clocks then 0 → exactly one SCEN pulse with coincident MCEN/CCEN. DPB=1 from that cycle until 16 clocks after PB falls, then 0.
- Long hold: N_dc=4, PB=1 for 200 clocks → 1 SCEN, then MCEN pulses at 17-clock spacing (5 total including the SCEN cycle). CCEN then stays 1 every cycle until PB=0.
- Release bounce: N_dc=4, in CCR toggle PB 1 for 1 clock at count 10 → release timer restarts; DPB falls 16 clocks after the last PB=0 resumes; no extra SCEN.
- Sync option: with DEBOUNCER_SYNC_EN, repeat the single-press case → SCEN appears 19 clocks after the PB edge, otherwise identical.
